// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream in, 32-bit little-endian word writes out.
// Optional trailing XOR checksum of all data words when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int          BUSWIDTH    = 32,
    parameter int          ADDRWIDTH   = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned ADDR_STRIDE = 4,
    parameter int unsigned MAX_WORDS   = 1024
) (
    input  logic                 clk,
    input  logic                 cpu_rstn,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic [ADDRWIDTH-1:0] wr_addr,
    output logic [BUSWIDTH-1:0]  wr_data,
    output logic                 wren,
    output logic [ADDRWIDTH-1:0] words_loaded,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 core_rstn
);

    // state | meaning
    // IDLE  | waiting for the first start pulse after reset
    // HDR   | collecting the 4-byte word count
    // DATA  | collecting data words, one memory write per word
    // CSUM  | collecting the 4-byte checksum (checksum builds only)
    // DONE  | image written; core released from reset
    // ERR   | bad word count or checksum; core held in reset
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

    localparam logic [ADDRWIDTH-1:0] BASE   = ADDRWIDTH'(BASE_ADDR);
    localparam logic [ADDRWIDTH-1:0] STRIDE = ADDRWIDTH'(ADDR_STRIDE);

    state_t      state;
    logic [1:0]  idx;
    logic [23:0] low_bytes;
    logic [31:0] count_n;
    logic [31:0] full_word;
    logic        accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    // The fourth byte completes the word combinationally so it can be acted on at its own handshake.
    assign full_word = {in_data, low_bytes};
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state        <= S_IDLE;
            idx          <= 2'd0;
            low_bytes    <= 24'd0;
            count_n      <= 32'd0;
            in_ready     <= 1'b0;
            wren         <= 1'b0;
            wr_addr      <= BASE;
            wr_data      <= '0;
            words_loaded <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            core_rstn    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= 32'd0;
`endif
        end else begin
            wren <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_HDR;
                        idx          <= 2'd0;
                        in_ready     <= 1'b1;
                        wr_addr      <= BASE;
                        words_loaded <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        core_rstn    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum         <= 32'd0;
`endif
                    end else if (state == S_DONE) begin
                        // Entering DONE coincides with the last wren, so this rises one cycle later.
                        core_rstn <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        idx <= idx + 2'd1;
                        if (idx != 2'd3) begin
                            low_bytes[8*idx +: 8] <= in_data;
                        end else begin
                            count_n <= full_word;
                            if (full_word > 32'(MAX_WORDS)) begin
                                state    <= S_ERR;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                                in_ready <= 1'b0;
                            end else if (full_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= S_CSUM;
`else
                                state    <= S_DONE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                in_ready <= 1'b0;
`endif
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        idx <= idx + 2'd1;
                        if (idx != 2'd3) begin
                            low_bytes[8*idx +: 8] <= in_data;
                        end else begin
                            wren         <= 1'b1;
                            wr_data      <= BUSWIDTH'(full_word);
                            wr_addr      <= BASE + words_loaded * STRIDE;
                            words_loaded <= words_loaded + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum         <= csum ^ full_word;
`endif
                            if (32'(words_loaded + 1'b1) == count_n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= S_CSUM;
`else
                                state    <= S_DONE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                in_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        idx <= idx + 2'd1;
                        if (idx != 2'd3) begin
                            low_bytes[8*idx +: 8] <= in_data;
                        end else begin
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                            if (full_word == csum) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a queue-based model of the stream format predicts every
// memory write and the final status; directed cases cover reset, bad headers and reloads.
module tb_imem_loader;

    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        cpu_rstn = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wren;
    logic [31:0] words_loaded;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_rstn;

    imem_loader dut (
        .clk(clk), .cpu_rstn(cpu_rstn), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .wr_addr(wr_addr), .wr_data(wr_data),
        .wren(wren), .words_loaded(words_loaded), .busy(busy), .done(done), .err(err),
        .core_rstn(core_rstn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          cyc = 0;
    int          wren_cnt = 0;
    int          last_wren_cyc = 0;
    int          rise_cyc = 0;
    logic        prev_core = 1'b0;

    // Every write must be the next one the model predicts; core must stay in reset while writes are owed.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (wren) begin
            check("wren_expected", (exp_addr.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_addr.size() > 0) begin
                check("wr_addr", wr_addr, exp_addr.pop_front());
                check("wr_data", wr_data, exp_data.pop_front());
            end
            wren_cnt++;
            last_wren_cyc = cyc;
        end
        if (core_rstn) check("core_rstn_early", exp_addr.size(), 0);
        if (core_rstn && !prev_core) rise_cyc = cyc;
        prev_core = core_rstn;
    end

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_in_ready"}, {31'd0, in_ready}, 0);
        check({pfx, "_wren"}, {31'd0, wren}, 0);
        check({pfx, "_wr_addr"}, wr_addr, 0);
        check({pfx, "_wr_data"}, wr_data, 0);
        check({pfx, "_words"}, words_loaded, 0);
        check({pfx, "_busy"}, {31'd0, busy}, 0);
        check({pfx, "_done"}, {31'd0, done}, 0);
        check({pfx, "_err"}, {31'd0, err}, 0);
        check({pfx, "_core_rstn"}, {31'd0, core_rstn}, 0);
    endtask

    // Called at a negedge; returns at a negedge. pct<0 means valid toggles every cycle.
    task automatic send(input logic [7:0] s[$], input int pct, input bit poke, output int ptr);
        int budget;
        bit acc;
        ptr = 0;
        budget = 0;
        while (ptr < s.size() && budget < 20000) begin
            if (pct < 0) in_valid = (budget % 2 == 0);
            else         in_valid = ($urandom_range(99) < pct);
            in_data = in_valid ? s[ptr] : 8'($urandom);
            start   = poke && (budget == 5);
            acc     = in_valid && in_ready;
            @(posedge clk);
            if (acc) ptr++;
            budget++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic push_word(inout logic [7:0] s[$], input logic [31:0] w);
        for (int b = 0; b < 4; b++) s.push_back(w[8*b +: 8]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] n, input logic [31:0] w[$], input int pct,
                        input bit bad_csum, input bit poke);
        logic [7:0]  s[$];
        logic [31:0] x;
        bit          hdr_err;
        bit          exp_err;
        int          wc0;
        int          ptr;
        s = {};
        x = 0;
        hdr_err = (n > MAXW);
        exp_err = hdr_err;
        push_word(s, n);
        if (!hdr_err) begin
            foreach (w[i]) begin
                push_word(s, w[i]);
                x ^= w[i];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            push_word(s, bad_csum ? ~x : x);
            exp_err = bad_csum;
`endif
        end
        pulse_start();
        check("start_busy", {31'd0, busy}, 1);
        check("start_in_ready", {31'd0, in_ready}, 1);
        check("start_done_clr", {31'd0, done | err}, 0);
        check("start_core_rstn", {31'd0, core_rstn}, 0);
        check("start_words", words_loaded, 0);
        if (!hdr_err) begin
            foreach (w[i]) begin
                exp_addr.push_back(32'(i) * 4);
                exp_data.push_back(w[i]);
            end
        end
        wc0 = wren_cnt;
        send(s, pct, poke, ptr);
        check("stream_consumed", ptr, s.size());
        repeat (3) @(negedge clk);
        check("end_done", {31'd0, done}, {31'd0, !exp_err});
        check("end_err", {31'd0, err}, {31'd0, exp_err});
        check("end_busy", {31'd0, busy}, 0);
        check("end_in_ready", {31'd0, in_ready}, 0);
        check("end_core_rstn", {31'd0, core_rstn}, {31'd0, !exp_err});
        check("end_words", words_loaded, hdr_err ? 32'd0 : n);
        check("end_wren_count", wren_cnt - wc0, hdr_err ? 0 : int'(n));
        check("end_pending", exp_addr.size(), 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (!exp_err && n != 0) check("core_rstn_rise", rise_cyc, last_wren_cyc + 1);
`endif
        exp_addr = {};
        exp_data = {};
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] spec_w[$];
        logic [7:0]  s[$];
        int          ptr;
        int          n;
        int          pcts[3];

        spec_w = {32'h0000_0013, 32'h0010_0093};
        pcts   = '{100, 70, 30};

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        cpu_rstn = 1'b1;
        @(negedge clk);

        load(2, spec_w, 100, 0, 0);
        load(2, spec_w, -1, 0, 0);
        w = {};
        load(0, w, 100, 0, 0);
        load(1025, w, 100, 0, 0);
        load(2, spec_w, 100, 0, 0);

        // Reset after 6 data bytes: first word written, second word half assembled.
        w = {};
        repeat (3) w.push_back($urandom);
        s = {};
        push_word(s, 3);
        push_word(s, w[0]);
        s.push_back(8'hA5);
        s.push_back(8'h5A);
        pulse_start();
        exp_addr.push_back(0);
        exp_data.push_back(w[0]);
        send(s, 100, 0, ptr);
        check("mid_stream", ptr, s.size());
        #2 cpu_rstn = 1'b0;
        #1 check_reset_vals("mid_rst");
        check("mid_pending", exp_addr.size(), 0);
        @(negedge clk);
        cpu_rstn = 1'b1;
        repeat (2) @(negedge clk);
        w = {};
        repeat (2) w.push_back($urandom);
        load(2, w, 100, 0, 0);

        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, 6);
            w = {};
            repeat (n) w.push_back($urandom);
            load(n, w, pcts[t % 3], ($urandom_range(3) == 0), (t == 4));
        end

        w = {};
        repeat (MAXW) w.push_back($urandom);
        load(MAXW, w, 100, 0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        load(2, spec_w, 100, 0, 0);
        load(2, spec_w, 100, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader; the write-side counterpart of the instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the instruction memory write port (wr_addr, wr_data, wren).
- Holds the core in reset until the image has been written completely and without error.

Parameters:
BUSWIDTH, 32, data word width; fixed at 32 (4 bytes per word).
ADDRWIDTH, 32, width of wr_addr and words_loaded.
BASE_ADDR, 0, address of the first word written.
ADDR_STRIDE, 4, address increment per word.
MAX_WORDS, 1024, largest accepted word count; matches the memory depth.

Ports:
clk  in  1  clock
cpu_rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a load
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid && in_ready
in_data  in  8  stream byte
wr_addr  out  ADDRWIDTH  memory write address
wr_data  out  BUSWIDTH  memory write data
wren  out  1  memory write strobe, one cycle per word
words_loaded  out  ADDRWIDTH  count of words written in the current load
busy  out  1  a load is in progress
done  out  1  load finished successfully; sticky
err  out  1  load failed; sticky
core_rstn  out  1  active-low reset to the core

Behaviour:
- Reset values: in_ready=0, wren=0, wr_addr=BASE_ADDR, wr_data=0, words_loaded=0, busy=0, done=0, err=0, core_rstn=0. Internal state=IDLE, byte index=0.
- Reset asserted mid-load aborts the load immediately. No further wren; all outputs return to their reset values.
- Stream format: 4-byte word count N (LSB first), then N words, each LSB first. With IMEM_LOADER_CHECKSUM_EN, a 4-byte checksum follows the last word.
- States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- IDLE: in_ready=0. A start pulse moves to HDR on the next edge and sets busy=1, byte index=0, words_loaded=0, wr_addr=BASE_ADDR.
- HDR: in_ready=1. On the 4th accepted byte:
  - N > MAX_WORDS -> ERR.
  - N == 0 -> CSUM if the checksum feature is enabled, else DONE.
  - otherwise -> DATA.
- DATA: in_ready=1. Each accepted byte shifts into the word at lane [8*idx +: 8]. On the 4th byte:
  - the next cycle has wren=1, wr_data=assembled word, wr_addr=BASE_ADDR + words_loaded*ADDR_STRIDE;
  - words_loaded increments in that same cycle;
  - write latency is 1 cycle after the 4th handshake.
- DATA continues to accept bytes while wren is high; there are no bubbles, so a 1-byte/cycle stream is sustained.
- After word N has been accepted: -> CSUM if the checksum feature is enabled, else DONE. wren for the final word still fires in the cycle after the transition.
- wr_addr wraps modulo 2^ADDRWIDTH; no other saturation applies.
- DONE: busy=0, done=1, in_ready=0. core_rstn rises one cycle after the final wren, so the core never leaves reset before the last word is written.
- ERR: busy=0, err=1, in_ready=0, core_rstn=0. The loader waits for start or reset.
- start while busy is ignored.
- start in DONE or ERR clears done/err, drops core_rstn to 0 on the next edge and enters HDR. A reload therefore re-resets the core.
- in_valid with in_ready=0 is not consumed; in_data is don't-care when in_valid=0.
- Simultaneous start and in_valid in IDLE: the byte is not consumed, because in_ready=0 in IDLE.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN:
- Defined:
  - a running XOR of all assembled data words is kept;
  - in CSUM, 4 bytes (LSB first) are compared against it;
  - match -> DONE;
  - mismatch -> ERR; the words are already written, but core_rstn stays 0.
- Undefined: the CSUM state and the XOR register do not exist; the transition is straight to DONE.

Test Plan:
- Reset, start, stream 02 00 00 00, 13 00 00 00, 93 00 10 00 at 1 byte/cycle:
  - wren pulses twice: (0x0, 0x00000013), then (0x4, 0x00100093);
  - words_loaded=2, done=1, core_rstn rises 1 cycle after the second wren.
- Same stream with in_valid toggling every other cycle -> identical writes and final state; no byte dropped or duplicated.
- Header 00 00 00 00 -> no wren; done=1 (checksum disabled).
- Header 01 04 00 00 (N=1025) -> err=1, core_rstn=0, in_ready=0, no wren. A following start restarts the load from HDR.
- Reset pulsed after 6 data bytes -> all outputs at reset values. A fresh start then reloads from BASE_ADDR with no stale partial word.
- Checksum enabled, words 0x00000013 and 0x00100093:
  - checksum 80 00 10 00 -> done=1;
  - checksum 00 00 00 00 -> err=1, core_rstn=0.
